filt_fetch_ctrl: RTL and testbench

Downstream consumer of the filter address generator's 32-bit word-address stream. Issues one 128-bit read per address to the memory port and buffers returned words in an in-order FIFO for the filter datapath. Uses credits to throttle the address generator: in_ready low maps directly onto the generator's pause. Signals completion once the last word has been delivered.

---
 rtl/filt_fetch_pkg.sv | 26 ++
 rtl/filt_word_fifo.sv | 85 ++++++++
 rtl/filt_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_filt_fetch_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/filt_fetch_pkg.sv
// Shared types and defaults for the filter fetch controller and its word FIFO.
package filt_fetch_pkg;

   localparam int unsigned DEPTH_DEF = 4;
   localparam int unsigned AW_DEF    = 32;
   localparam int unsigned DW_DEF    = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      logic [31:0] r;
      if (v == 32'hFFFF_FFFF) begin
         r = v;
      end else begin
         r = v + 32'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/filt_word_fifo.sv
// In-order DEPTH x DW word buffer. The head word comes straight from registered
// storage, so data written in a cycle is visible at the head no earlier than the next.
module filt_word_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 128
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [DW-1:0]          wdata_i,
   input  logic                   pop_i,
   output logic [DW-1:0]          rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok_s;
   logic          pop_ok_s;

   // A push into a full FIFO is only honoured when the head leaves in the same cycle.
   always_comb begin
      pop_ok_s  = pop_i & (count_q != {CW{1'b0}});
      push_ok_s = push_i & ((count_q != CW'(DEPTH)) | pop_ok_s);
   end

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Word storage; cleared so the head reads zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= {DW{1'b0}};
         end
      end else if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == {CW{1'b0}});
   assign count_o = count_q;

endmodule

// File: rtl/filt_fetch_ctrl.sv
// Fetch controller: turns the address stream into memory reads under a credit limit
// and buffers returns in order. Optional stall/word counters under FILT_FETCH_STATS_EN.
module filt_fetch_ctrl
   import filt_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned DW    = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr,
   input  logic          in_last,
   output logic          in_ready,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic          busy,
   output logic          done,
   output logic          err
`ifdef FILT_FETCH_STATS_EN
   ,
   output logic [31:0]   stall_cnt,
   output logic [31:0]   word_cnt
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned UW = CW + 1;

   state_e        state_q, state_d;
   logic          req_valid_q, req_valid_d;
   logic [AW-1:0] req_addr_q, req_addr_d;
   logic [CW-1:0] outst_q, outst_d;
   logic          err_q, err_d;

   logic [CW-1:0] fifo_count_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic [DW-1:0] fifo_rdata_s;

   logic [UW-1:0] used_s;
   logic          in_ready_s, accept_s, gnt_s, pop_s;
   logic          rv_push_s, rv_err_s, start_ok_s, drained_s;
   logic          busy_s, done_s;

   // Handshake decode; a return with nothing outstanding is dropped and flagged.
   always_comb begin
      used_s     = UW'(fifo_count_s) + UW'(outst_q) + UW'(req_valid_q);
      start_ok_s = start & ((state_q == IDLE) | (state_q == DONE));
      gnt_s      = req_valid_q & mem_gnt;
      rv_push_s  = mem_rvalid & (outst_q != {CW{1'b0}});
      rv_err_s   = mem_rvalid & (outst_q == {CW{1'b0}});
      pop_s      = ~fifo_empty_s & out_ready;
      drained_s  = ~req_valid_q & (outst_q == {CW{1'b0}}) & fifo_empty_s;
      accept_s   = in_valid & in_ready_s;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_ok_s) state_d = FETCH;
            else            state_d = IDLE;
         end
         FETCH: begin
            if (accept_s & in_last) state_d = DRAIN;
            else                    state_d = FETCH;
         end
         DRAIN: begin
            if (drained_s) state_d = DONE;
            else           state_d = DRAIN;
         end
         DONE: begin
            if (start_ok_s) state_d = FETCH;
            else            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode; full is redundant with the credit test but kept as a guard.
   always_comb begin
      in_ready_s = 1'b0;
      busy_s     = 1'b0;
      done_s     = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_s = 1'b0;
         end
         FETCH: begin
            busy_s     = 1'b1;
            in_ready_s = (used_s < UW'(DEPTH)) & ~fifo_full_s & (~req_valid_q | mem_gnt);
         end
         DRAIN: begin
            busy_s = 1'b1;
         end
         DONE: begin
            done_s = 1'b1;
         end
         default: begin
            in_ready_s = 1'b0;
         end
      endcase
   end

   // Request register, outstanding count and sticky error next-state.
   always_comb begin
      req_valid_d = req_valid_q;
      req_addr_d  = req_addr_q;
      if (accept_s) begin
         req_valid_d = 1'b1;
         req_addr_d  = in_addr;
      end else if (gnt_s) begin
         req_valid_d = 1'b0;
      end else begin
         req_valid_d = req_valid_q;
      end
      case ({gnt_s, rv_push_s})
         2'b10:   outst_d = outst_q + CW'(1);
         2'b01:   outst_d = outst_q - CW'(1);
         default: outst_d = outst_q;
      endcase
      err_d = err_q | rv_err_s;
   end

   // Request, outstanding and error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_valid_q <= 1'b0;
         req_addr_q  <= {AW{1'b0}};
         outst_q     <= {CW{1'b0}};
         err_q       <= 1'b0;
      end else begin
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         outst_q     <= outst_d;
         err_q       <= err_d;
      end
   end

   filt_word_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rv_push_s),
      .wdata_i (mem_rdata),
      .pop_i   (pop_s),
      .rdata_o (fifo_rdata_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

`ifdef FILT_FETCH_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] word_cnt_q, word_cnt_d;

   // Statistics next-state: cleared by an accepted start.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      word_cnt_d  = word_cnt_q;
      if (start_ok_s) begin
         stall_cnt_d = 32'd0;
         word_cnt_d  = 32'd0;
      end else begin
         if ((state_q == FETCH) & in_valid & ~in_ready_s) begin
            stall_cnt_d = sat_inc32(stall_cnt_q);
         end else begin
            stall_cnt_d = stall_cnt_q;
         end
         if (pop_s) begin
            word_cnt_d = sat_inc32(word_cnt_q);
         end else begin
            word_cnt_d = word_cnt_q;
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
         word_cnt_q  <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign word_cnt  = word_cnt_q;
`endif

   assign in_ready  = in_ready_s;
   assign mem_req   = req_valid_q;
   assign mem_addr  = req_addr_q;
   assign out_valid = ~fifo_empty_s;
   assign out_data  = fifo_rdata_s;
   assign busy      = busy_s;
   assign done      = done_s;
   assign err       = err_q;

endmodule

// File: tb/tb_filt_fetch_ctrl.sv
// Randomized bench for filt_fetch_ctrl against a count/queue reference model.
module tb_filt_fetch_ctrl;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 128;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, in_valid, in_last, mem_gnt, mem_rvalid, out_ready;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] mem_rdata;
   logic          in_ready, mem_req, out_valid, busy, done, err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] out_data;
`ifdef FILT_FETCH_STATS_EN
   logic [31:0]   stall_cnt, word_cnt;
`endif

   filt_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_addr(in_addr), .in_last(in_last), .in_ready(in_ready),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .done(done), .err(err)
`ifdef FILT_FETCH_STATS_EN
      , .stall_cnt(stall_cnt), .word_cnt(word_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
      return {a ^ 32'hA5A5_5A5A, ~a, a + 32'd1, a};
   endfunction

   // Reference model: mode 0 idle, 1 fetching, 2 draining, 3 done.
   int            mode;
   int            n_acc, n_gnt, n_ret, n_pop;
   logic [AW-1:0] acc_addr[$];
   int            due_q[$];
   bit            exp_err;
   int            stall_m, word_m;

   task automatic model_clear();
      mode = 0; n_acc = 0; n_gnt = 0; n_ret = 0; n_pop = 0;
      acc_addr.delete(); due_q.delete();
      stall_m = 0; word_m = 0;
   endtask

   task automatic drive_idle();
      start = 1'b0; in_valid = 1'b0; in_addr = '0; in_last = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      drive_idle();
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_mem_req", mem_req, 1'b0);
      check_eq("rst_in_ready", in_ready, 1'b0);
      check_eq("rst_err", err, 1'b0);
      check_eq("rst_out_data", out_data, '0);
      check_eq("rst_mem_addr", mem_addr, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      exp_err = 1'b0;
   endtask

   // One transfer of n words; abort_occ > 0 returns early once that many words are buffered.
   task automatic run_xfer(input int n, input logic [AW-1:0] base, input int gnt_pct,
                           input int rdy_pct, input int lat, input int hold,
                           input int gnt_stall, input int abort_occ);
      int  cyc = 0;
      int  stall_seen = 0;
      bit  fin = 1'b0;
      bit  exp_ir, exp_req, exp_ov, a, g, p, r;
      while (!fin) begin
         @(negedge clk);
         start = (cyc == 0) ? 1'b1 : ((mode == 1 || mode == 2) && $urandom_range(0, 7) == 0);
         if (mode == 1 && n_acc < n) begin
            in_valid = ($urandom_range(0, 99) < 80);
            in_addr  = base + 32'(n_acc);
            in_last  = (n_acc == n - 1);
         end else begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_addr  = $urandom;
            in_last  = 1'($urandom_range(0, 1));
         end
         if (n_gnt == 0 && stall_seen < gnt_stall) mem_gnt = 1'b0;
         else mem_gnt = ($urandom_range(0, 99) < gnt_pct);
         if (due_q.size() > 0 && due_q[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word_of(acc_addr[n_ret]);
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
         end
         out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
         #1;
         exp_ir  = (mode == 1) && (n_acc - n_pop < DEPTH) && (n_acc == n_gnt || mem_gnt);
         exp_req = (n_acc > n_gnt);
         exp_ov  = (n_ret > n_pop);
         check_eq("in_ready", in_ready, exp_ir);
         check_eq("mem_req", mem_req, exp_req);
         if (exp_req) check_eq("mem_addr", mem_addr, acc_addr[n_gnt]);
         check_eq("out_valid", out_valid, exp_ov);
         if (exp_ov) check_eq("out_data", out_data, word_of(acc_addr[n_pop]));
         check_eq("busy", busy, (mode == 1 || mode == 2));
         check_eq("done", done, (mode == 3));
         check_eq("err", err, exp_err);
`ifdef FILT_FETCH_STATS_EN
         check_eq("stall_cnt", stall_cnt, 32'(stall_m));
         check_eq("word_cnt", word_cnt, 32'(word_m));
`endif
         if (hold > 0 && cyc == hold - 1 && n >= DEPTH) check_eq("credit_limit", n_acc, DEPTH);
         a = in_valid && exp_ir;
         g = exp_req && mem_gnt;
         p = exp_ov && out_ready;
         r = mem_rvalid;
         if (exp_req && n_gnt == 0 && !mem_gnt) stall_seen++;
         if (mode == 1 && in_valid && !exp_ir) stall_m++;
         if (mode == 3) fin = 1'b1;
         if (abort_occ > 0 && (n_ret - n_pop) >= abort_occ) fin = 1'b1;
         if (cyc > 3000) begin
            check_eq("timeout", 1'b0, 1'b1);
            fin = 1'b1;
         end
         @(posedge clk);
         case (mode)
            0, 3: if (start) begin model_clear(); mode = 1; end
            1: if (a && in_last) mode = 2;
            2: if (n_acc == n_pop) mode = 3;
            default: mode = 0;
         endcase
         if (a) begin acc_addr.push_back(in_addr); n_acc++; end
         if (r) begin
            if (n_gnt == n_ret) exp_err = 1'b1;
            else begin n_ret++; void'(due_q.pop_front()); end
         end
         if (g) begin n_gnt++; due_q.push_back(cyc + lat); end
         if (p) begin n_pop++; word_m++; end
         cyc++;
      end
   endtask

   initial begin
      rst_n = 1'b1;
      drive_idle();
      model_clear();
      exp_err = 1'b0;
      apply_reset();

      // Basic 8-word transfer, immediate grant, 2-cycle latency, always ready.
      run_xfer(8, 32'h100, 100, 100, 2, 0, 0, 0);
      // Credit limit: consumer stalled for 20 cycles.
      run_xfer(8, 32'h140, 100, 100, 2, 20, 0, 0);
      // First request not granted for 5 cycles.
      run_xfer(8, 32'h100, 100, 100, 2, 0, 5, 0);
      // Random traffic.
      for (int k = 0; k < 6; k++) begin
         run_xfer($urandom_range(1, 12), $urandom, $urandom_range(30, 100),
                  $urandom_range(20, 100), $urandom_range(1, 4), 0, 0, 0);
      end

      // Stray return in IDLE sets the sticky error.
      apply_reset();
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      check_eq("err_set", err, 1'b1);
      check_eq("err_fifo_empty", out_valid, 1'b0);
      exp_err = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_eq("err_sticky", err, 1'b1);
      run_xfer(5, 32'h2000, 70, 70, 3, 0, 0, 0);

      // Reset mid-FETCH with 3 words buffered, then a fresh 2-word transfer.
      apply_reset();
      run_xfer(8, 32'h200, 100, 0, 1, 0, 0, 3);
      apply_reset();
      run_xfer(2, 32'h300, 100, 100, 2, 0, 0, 0);

      // Long consumer stall with the generator pushing against the credit limit.
      run_xfer(8, 32'h400, 100, 100, 2, 14, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
